// File: rtl/demux_8_32_deser.sv
// demux_8_32_deser: 8-to-32 bit deserializer, MSB byte first; define ABORT_FLAG_EN to add err_out.
module demux_8_32_deser (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  output logic        valid_out,
  output logic [31:0] data_out
`ifdef ABORT_FLAG_EN
  ,
  output logic        err_out
`endif
);
  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
  state_t      state, state_nx;
  logic [31:0] asm_q, asm_nx;
  logic [1:0]  lane;
  logic        done;
  always_comb begin
    lane     = 2'd3 - state;
    done     = valid_in && (state == S3);
    state_nx = valid_in ? state_t'(state + 2'd1) : S0;
    asm_nx   = asm_q;
    if (valid_in) asm_nx[{lane, 3'b000} +: 8] = data_in;
  end
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= S0;
      asm_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nx;
      asm_q     <= asm_nx;
      valid_out <= done;
      if (done) data_out <= {asm_q[31:8], data_in};
    end
  end
`ifdef ABORT_FLAG_EN
  logic abort;
  assign abort = !valid_in && (state != S0);
  always_ff @(posedge clk_4f) begin
    if (reset) err_out <= 1'b0;
    else err_out <= abort;
  end
`endif
endmodule

// File: tb/tb_demux_8_32_deser.sv
// tb_demux_8_32_deser: vector table, directed corner sequences and randomized traffic vs a byte-queue model.
module tb_demux_8_32_deser;
  logic        clk_4f = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        valid_out;
  logic [31:0] data_out;
`ifdef ABORT_FLAG_EN
  logic        err_out;
`endif
  int passed = 0;
  int total = 0;

  demux_8_32_deser dut (
    .clk_4f(clk_4f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out)
`ifdef ABORT_FLAG_EN
    , .err_out(err_out)
`endif
  );

  always #5 clk_4f = ~clk_4f;

  logic [7:0]  q[$];
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_data = '0;

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      q.delete();
      m_data = '0;
    end else if (v) begin
      q.push_back(d);
      if (q.size() == 4) begin
        m_data  = {q[0], q[1], q[2], q[3]};
        m_valid = 1'b1;
        q.delete();
      end
    end else if (q.size() > 0) begin
      m_err = 1'b1;
      q.delete();
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    reset = r;
    valid_in = v;
    data_in = d;
    @(posedge clk_4f);
    #1;
    model_step(r, v, d);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid_out"}, {31'b0, valid_out}, {31'b0, m_valid});
    chk({tag, " data_out"}, data_out, m_data);
`ifdef ABORT_FLAG_EN
    chk({tag, " err_out"}, {31'b0, err_out}, {31'b0, m_err});
`endif
  endtask

  typedef struct packed {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;
  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'hEE, 1'b0, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'hBB, 1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hCC, 1'b0, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hDD, 1'b1, 32'hAABBCCDD, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b0, 32'hAABBCCDD, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h22, 1'b0, 32'hAABBCCDD, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h33, 1'b0, 32'hAABBCCDD, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h44, 1'b1, 32'h11223344, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h11, 1'b0, 32'h11223344, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h22, 1'b0, 32'h11223344, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h99, 1'b0, 32'h11223344, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h11223344, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h11223344, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'hFF, 1'b0, 32'h11223344, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'hFF, 1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h55, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 8'h66, 1'b0, 32'hFFFFFFFF, 1'b0};

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d valid_out", i), {31'b0, valid_out}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d data_out", i), data_out, vecs[i].ed);
`ifdef ABORT_FLAG_EN
      chk($sformatf("vec%0d err_out", i), {31'b0, err_out}, {31'b0, vecs[i].ee});
`endif
    end

    drive(1'b0, 1'b1, 8'hA1);
    drive(1'b0, 1'b1, 8'hA2);
    drive(1'b0, 1'b1, 8'hA3);
    drive(1'b1, 1'b1, 8'hA4);
    chk("rst_mid valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_mid data_out", data_out, 32'h00000000);
`ifdef ABORT_FLAG_EN
    chk("rst_mid err_out", {31'b0, err_out}, 32'd0);
`endif
    drive(1'b0, 1'b1, 8'h01);
    check_model("after_rst b0");
`ifdef ABORT_FLAG_EN
    chk("after_rst no err", {31'b0, err_out}, 32'd0);
`endif
    drive(1'b0, 1'b1, 8'h02);
    drive(1'b0, 1'b1, 8'h03);
    drive(1'b0, 1'b1, 8'h04);
    chk("after_rst valid_out", {31'b0, valid_out}, 32'd1);
    chk("after_rst data_out", data_out, 32'h01020304);

    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 8'($urandom));
      chk($sformatf("idle%0d data_out", i), data_out, 32'h01020304);
      chk($sformatf("idle%0d valid_out", i), {31'b0, valid_out}, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux_8_32_deser.md
DEMUX_8_32_DESER -- requirements
Module: demux_8_32_deser

Interface
REQ-001 The block SHALL have the port clk_4f, input, 1 bit: single clock, byte rate; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk_4f.
REQ-003 The block SHALL have the port valid_in, input, 1 bit: data_in carries a valid byte this cycle.
REQ-004 The block SHALL have the port data_in, input, 8 bits: serial byte stream, most significant byte of each word first.
REQ-005 The block SHALL have the port valid_out, output, 1 bit: one-cycle pulse when data_out carries a newly completed word.
REQ-006 The block SHALL have the port data_out, output, 32 bits: last completed word, held until the next word completes.
REQ-007 The block SHALL have the port err_out, output, 1 bit, present only with ABORT_FLAG_EN: one-cycle pulse when a partial word is discarded.

Function
REQ-008 The block SHALL implement an FSM with states S0 (0 bytes held), S1, S2 and S3 (1, 2 and 3 bytes held).
REQ-009 Sx with valid_in=1 SHALL capture data_in into byte lane 3-x of a 32-bit shift/assembly register and advance to S(x+1); S3 with valid_in=1 SHALL return to S0.
REQ-010 On the edge that samples the 4th valid byte, the block SHALL load data_out = {b0,b1,b2,b3}, with b0 = first byte, into bits [31:24].
REQ-011 valid_out SHALL be 1 for exactly the cycle following that edge and 0 otherwise; latency from 4th byte sample to valid_out = 1 cycle.
REQ-012 Back-to-back words (valid_in continuously 1) SHALL yield valid_out every 4th cycle with no lost bytes and no idle cycle.
REQ-013 valid_in=0 in S0 SHALL keep S0 with no output change.
REQ-014 valid_in=0 in S1, S2 or S3 SHALL discard the partial word and return to S0; data_out SHALL keep its previous value and valid_out SHALL stay 0.
REQ-015 Bytes arriving with valid_in=0 SHALL never be captured.
REQ-016 data_out SHALL change only on word completion or reset; it SHALL never be visible partially assembled.

Reset
REQ-017 reset=1 at a rising edge SHALL force S0, data_out=32'h00000000, valid_out=0, err_out=0, and clear the assembly register.
REQ-018 reset SHALL take priority over valid_in; a byte presented in the reset cycle SHALL be dropped.
REQ-019 Reset during S1-S3 SHALL discard the partial word without asserting err_out.
REQ-020 The first byte with valid_in=1 after reset deasserts SHALL be treated as b0.

Configuration
REQ-021 The macro ABORT_FLAG_EN SHALL control whether err_out is compiled in.
REQ-022 With ABORT_FLAG_EN defined, err_out SHALL exist and SHALL pulse 1 for one cycle following each REQ-014 abort.
REQ-023 Without ABORT_FLAG_EN, err_out and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 Reset then bytes AA,BB,CC,DD on 4 consecutive cycles -> valid_out=1 one cycle later with data_out=32'hAABBCCDD.
REQ-025 Continuous stream AA,BB,CC,DD,11,22,33,44 -> two valid_out pulses 4 cycles apart, with data_out 32'hAABBCCDD then 32'h11223344.
REQ-026 Bytes 11,22 followed by a valid_in=0 cycle, then FF,FF,FF,FF -> no pulse for the partial word, then data_out=32'hFFFFFFFF; with ABORT_FLAG_EN, err_out pulses once after the gap.
REQ-027 reset asserted after 3 bytes of a word -> S0, data_out=0, no err_out; the next 4 bytes 01,02,03,04 -> data_out=32'h01020304.
REQ-028 valid_in=0 for 10 cycles after a completed word -> data_out holds its value and valid_out stays 0.
